// File: rtl/picomips_pkg.sv
// Types and widths shared between the picoMIPS register file and the logic
// that reads it out for debug.
package picomips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } dump_state_t;

  localparam int REG_N  = 8;
  localparam int REG_AW = 3;

endpackage

// File: rtl/reg_dump_if.sv
// Valid/ready stream carrying one (address, data) pair of a register dump.
interface reg_dump_if
  import picomips_pkg::*;
#(
  parameter int N  = REG_N,
  parameter int AW = REG_AW
) ();

  logic                valid;
  logic                ready;
  logic [AW-1:0]       addr;
  logic signed [N-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/reg_dump.sv
// Walks the register file's second read port over every address and streams
// each (address, data) pair out while the core is halted.
module reg_dump
  import picomips_pkg::*;
#(
  parameter int N         = REG_N,
  parameter int NREGS     = 8,
  parameter int AW        = REG_AW,
  parameter int SKIP_ZERO = 0
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                start,
  input  logic                abort,
  output logic [AW-1:0]       rf_raddr,
  input  logic signed [N-1:0] rf_rdata,
  reg_dump_if.master          dump,
  output logic                busy,
  output logic                done
);

  localparam logic [AW-1:0] FIRST_ADDR = (SKIP_ZERO != 0) ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NREGS - 1);

  dump_state_t         state_reg, state_next;
  logic [AW-1:0]       ptr_reg, ptr_next;
  logic                valid_reg, valid_next;
  logic [AW-1:0]       addr_reg, addr_next;
  logic signed [N-1:0] data_reg, data_next;
  logic                done_reg, done_next;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    valid_next = valid_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    rf_raddr   = '0;
    case (state_reg)
      IDLE: begin
        // abort in the same cycle as start keeps the engine idle
        if (start && !abort) begin
          state_next = FETCH;
          ptr_next   = FIRST_ADDR;
        end
      end
      FETCH: begin
        rf_raddr = ptr_reg;
        if (abort) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end else begin
          addr_next  = ptr_reg;
          data_next  = rf_rdata;
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        rf_raddr = ptr_reg;
        // abort outranks a handshake in the same cycle
        if (abort) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end else if (dump.ready) begin
          valid_next = 1'b0;
          if (ptr_reg == LAST_ADDR) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            ptr_next   = ptr_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      valid_reg <= valid_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign dump.valid = valid_reg;
  assign dump.addr  = addr_reg;
  assign dump.data  = data_reg;

endmodule
